// File: rtl/mac_chk_pkg.sv
// mac_chk_pkg: shared constants and FSM state type for the MAC result checker.
package mac_chk_pkg;
    localparam int DATA_W    = 11;
    localparam int EXP_COUNT = 10;
    localparam int CNT_W     = 8;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/mac_chk_fifo.sv
// mac_chk_fifo: synchronous FIFO of expected values; the extra pointer bit tells full from empty.
module mac_chk_fifo #(
    parameter int DATA_W = 11,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0]       wr_q, rd_q;
    logic [DATA_W-1:0] mem_q [DEPTH];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push && !full) wr_q <= wr_q + (AW+1)'(1);
            if (pop && !empty) rd_q <= rd_q + (AW+1)'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (push && !full) mem_q[wr_q[AW-1:0]] <= wdata;
    end
    assign rdata = mem_q[rd_q[AW-1:0]];
    assign empty = wr_q == rd_q;
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
endmodule

// File: rtl/mac_result_checker.sv
// mac_result_checker: compares each MAC result against the oldest queued expected value
// and keeps saturating pass/error counters until a programmed number of results is checked.
import mac_chk_pkg::*;
module mac_result_checker #(
    parameter int DATA_W    = mac_chk_pkg::DATA_W,
    parameter int DEPTH     = 16,
    parameter int EXP_COUNT = mac_chk_pkg::EXP_COUNT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              exp_valid,
    input  logic [DATA_W-1:0] exp_data,
    output logic              exp_ready,
    input  logic              out_valid,
    input  logic [DATA_W-1:0] mac_out,
    output logic              err_pulse,
    output logic [CNT_W-1:0]  check_count,
    output logic [CNT_W-1:0]  err_count,
    output logic              unexpected,
    output logic              fifo_full,
    output logic              done,
    output logic              pass
);
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   chk_q, chk_d, err_q, err_d;
    logic               unexp_q, unexp_d, errp_q, errp_d;
    logic               empty, proc, hit, miss;
    logic [DATA_W-1:0]  head;
    logic [CNT_W:0]     sum;

    mac_chk_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk(clk), .rst_n(rst_n),
        .push(exp_valid), .pop(proc && !empty),
        .wdata(exp_data), .rdata(head),
        .full(fifo_full), .empty(empty)
    );

    // A result coinciding with start is dropped so the new run begins clean.
    assign proc = (state_q == RUN) && out_valid && !start;
    assign hit  = proc && !empty && (head == mac_out);
    assign miss = proc && (empty || (head != mac_out));

    always_comb begin
        chk_d   = start ? '0 : (hit && chk_q != '1) ? chk_q + CNT_W'(1) : chk_q;
        err_d   = start ? '0 : (miss && err_q != '1) ? err_q + CNT_W'(1) : err_q;
        unexp_d = start ? 1'b0 : unexp_q || (proc && empty);
        errp_d  = miss;
        sum     = {1'b0, chk_d} + {1'b0, err_d};
        state_d = start ? RUN : (proc && sum >= (CNT_W+1)'(EXP_COUNT)) ? DONE : state_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            chk_q   <= '0;
            err_q   <= '0;
            unexp_q <= 1'b0;
            errp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            chk_q   <= chk_d;
            err_q   <= err_d;
            unexp_q <= unexp_d;
            errp_q  <= errp_d;
        end
    end

    assign exp_ready   = !fifo_full;
    assign err_pulse   = errp_q;
    assign check_count = chk_q;
    assign err_count   = err_q;
    assign unexpected  = unexp_q;
    assign done        = state_q == DONE;
    assign pass        = done && (err_q == '0) && (chk_q == CNT_W'(EXP_COUNT));
endmodule

// File: tb/tb_mac_result_checker.sv
// tb_mac_result_checker: directed and random stimulus scored against a queue-based model.
module tb_mac_result_checker;
    localparam int DW = 11;
    localparam int DEPTH = 16;
    localparam int NEXP = 10;

    logic clk = 0, rst_n = 0, start = 0, exp_valid = 0, out_valid = 0;
    logic [DW-1:0] exp_data = '0, mac_out = '0;
    logic exp_ready, err_pulse, unexpected, fifo_full, done, pass;
    logic [7:0] check_count, err_count;

    mac_result_checker #(.DATA_W(DW), .DEPTH(DEPTH), .EXP_COUNT(NEXP)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .exp_valid(exp_valid), .exp_data(exp_data), .exp_ready(exp_ready),
        .out_valid(out_valid), .mac_out(mac_out), .err_pulse(err_pulse),
        .check_count(check_count), .err_count(err_count), .unexpected(unexpected),
        .fifo_full(fifo_full), .done(done), .pass(pass)
    );

    always #5 clk = ~clk;

    int n_total = 0, n_pass = 0;
    int q[$];
    int m_run = 0, m_done = 0, m_chk = 0, m_err = 0, m_unexp = 0, m_errp = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        q.delete();
        m_run = 0; m_done = 0; m_chk = 0; m_err = 0; m_unexp = 0; m_errp = 0;
    endtask

    task automatic model_step();
        bit room;
        int e;
        room = q.size() < DEPTH;
        m_errp = 0;
        if (start) begin
            m_run = 1; m_done = 0; m_chk = 0; m_err = 0; m_unexp = 0;
        end else if (m_run && out_valid) begin
            if (q.size() == 0) begin
                m_err = (m_err < 255) ? m_err + 1 : 255; m_errp = 1; m_unexp = 1;
            end else begin
                e = q.pop_front();
                if (e == int'(mac_out)) m_chk = (m_chk < 255) ? m_chk + 1 : 255;
                else begin m_err = (m_err < 255) ? m_err + 1 : 255; m_errp = 1; end
            end
            if (m_chk + m_err >= NEXP) begin m_run = 0; m_done = 1; end
        end
        if (exp_valid && room) q.push_back(int'(exp_data));
    endtask

    task automatic compare_all();
        check("exp_ready", exp_ready, q.size() < DEPTH);
        check("fifo_full", fifo_full, q.size() == DEPTH);
        check("err_pulse", err_pulse, m_errp);
        check("check_count", check_count, m_chk);
        check("err_count", err_count, m_err);
        check("unexpected", unexpected, m_unexp);
        check("done", done, m_done);
        check("pass", pass, m_done && m_err == 0 && m_chk == NEXP);
    endtask

    task automatic cyc(input logic s, input logic ev, input logic [DW-1:0] ed,
                       input logic ov, input logic [DW-1:0] mo);
        start = s; exp_valid = ev; exp_data = ed; out_valid = ov; mac_out = mo;
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic push_seq(input int n);
        for (int i = 1; i <= n; i++) cyc(0, 1, DW'(i), 0, '0);
    endtask

    initial begin
        logic [DW-1:0] mo;
        model_reset();
        #12 rst_n = 1;
        #1 compare_all();
        check("reset_ready", exp_ready, 1);

        // results while IDLE are ignored
        for (int i = 0; i < 3; i++) cyc(0, 0, '0, 1, DW'(i));
        check("idle_err", err_count, 0);

        // clean run of ten matching results
        push_seq(10);
        cyc(1, 0, '0, 0, '0);
        for (int i = 1; i <= 10; i++) cyc(0, 0, '0, 1, DW'(i));
        check("run1_done", done, 1);
        check("run1_pass", pass, 1);
        check("run1_chk", check_count, 10);

        // results in DONE are ignored
        for (int i = 0; i < 3; i++) cyc(0, 0, '0, 1, DW'(i));
        check("done_hold", err_count, 0);

        // fourth result corrupted
        push_seq(10);
        cyc(1, 0, '0, 0, '0);
        for (int i = 1; i <= 10; i++) begin
            cyc(0, 0, '0, 1, (i == 4) ? DW'('h7FF) : DW'(i));
            if (i == 4) check("bad_pulse", err_pulse, 1);
        end
        check("run2_err", err_count, 1);
        check("run2_chk", check_count, 9);
        check("run2_pass", pass, 0);

        // unexpected result on empty FIFO, then no-bypass push
        cyc(1, 0, '0, 0, '0);
        cyc(0, 0, '0, 1, DW'('h123));
        check("unexp_flag", unexpected, 1);
        cyc(0, 1, DW'('h123), 1, DW'('h123));
        check("nobypass_err", err_count, 2);
        cyc(0, 0, '0, 1, DW'('h123));
        check("queued_match", check_count, 1);

        // fill past capacity, then one pop reopens space
        for (int i = 0; i < 18; i++) cyc(0, 1, DW'($urandom), 0, '0);
        check("full_ready", exp_ready, 0);
        mo = DW'(q[0]);
        cyc(0, 1, DW'($urandom), 1, mo);
        check("pop_ready", exp_ready, 1);
        cyc(0, 1, DW'($urandom), 0, '0);

        // asynchronous reset mid-run
        #3 rst_n = 0;
        model_reset();
        #1 compare_all();
        #2 rst_n = 1;

        // start coinciding with a result in RUN drops the result
        cyc(1, 1, DW'(5), 0, '0);
        cyc(0, 1, DW'(6), 1, DW'(5));
        cyc(1, 0, '0, 1, DW'(6));
        check("start_drop", check_count, 0);
        cyc(0, 0, '0, 1, DW'(6));

        for (int i = 0; i < 1500; i++) begin
            mo = (q.size() > 0 && $urandom_range(3) != 0) ? DW'(q[0]) : DW'($urandom);
            cyc($urandom_range(30) == 0, $urandom_range(1) == 1, DW'($urandom),
                $urandom_range(1) == 1, mo);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
